// File: rtl/bcd_downcount_pkg.sv
// Shared types, constants and helpers for the BCD countdown timer.
package bcd_downcount_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } bcd_state_t;

  // Any non-decimal nibble (A..F) is stored as 9.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] digit);
    return (digit > BCD_MAX) ? BCD_MAX : digit;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of the countdown chain: load has priority over decrement,
// 0 decrements to 9 and raises borrow_out for the next more significant digit.
module bcd_digit_down
  import bcd_downcount_pkg::*;
(
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             load,
  input  logic [BCD_W-1:0] load_digit,
  input  logic             dec,
  output logic [BCD_W-1:0] digit,
  output logic             borrow_out
);

  logic [BCD_W-1:0] r_digit;

  // Digit register: load, else decrement with wrap 0 -> 9.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_digit <= '0;
    end else if (load) begin
      r_digit <= load_digit;
    end else if (dec) begin
      r_digit <= (r_digit == '0) ? BCD_MAX : (r_digit - 1'b1);
    end
  end

  assign digit      = r_digit;
  assign borrow_out = dec && (r_digit == '0);

endmodule

// File: rtl/bcd_downcount.sv
// Multi-digit BCD countdown timer with load, start/pause and a one-cycle
// done pulse on expiry.
// Optional feature: define BCD_DOWNCOUNT_RELOAD_EN for auto-reload, where
// expiry reloads the last loaded preset and the timer keeps running.
//
//   state  | meaning
//   IDLE   | count holds, waiting for start with a non-zero count
//   RUN    | one BCD decrement per tick_en
//   PAUSED | count holds, tick_en ignored, start resumes
module bcd_downcount
  import bcd_downcount_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_value,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    tick_en,
  output logic [BCD_W*DIGITS-1:0] count,
  output logic                    zero,
  output logic                    busy,
  output logic                    done
);

  localparam int W = BCD_W * DIGITS;
  localparam logic [W-1:0] COUNT_ONE = W'(1);

  bcd_state_t r_state;
  bcd_state_t w_state_nxt;
  logic       w_done_nxt;
  logic       r_done;
  logic       r_busy;

  logic [W-1:0]    r_reload;
  logic [W-1:0]    w_load_clamped;
  logic [W-1:0]    w_dig_value;
  logic            w_dig_load;
  logic            w_tick_run;
  logic            w_count_is_one;
  logic            w_expire;
  logic            w_reload_now;
  logic            w_underflow;
  logic [DIGITS:0] w_borrow;

  // Clamp every preset digit independently.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_clamp
    assign w_load_clamped[gi*BCD_W +: BCD_W] = bcd_clamp(load_value[gi*BCD_W +: BCD_W]);
  end

  assign zero           = (count == '0);
  assign w_count_is_one = (count == COUNT_ONE);

  // A tick is consumed only in RUN and only when neither load nor pause wins.
  assign w_tick_run = !load && (r_state == RUN) && !pause && tick_en;
  assign w_expire   = w_tick_run && w_count_is_one;

`ifdef BCD_DOWNCOUNT_RELOAD_EN
  assign w_reload_now = w_expire;
`else
  assign w_reload_now = 1'b0;
`endif

  // Reload replaces the final decrement, so the chain sees a load, not a dec.
  assign w_dig_load  = load || w_reload_now;
  assign w_dig_value = load ? w_load_clamped : r_reload;
  assign w_borrow[0] = w_tick_run && !w_reload_now;

  // A borrow out of the MSD means a tick hit 0 in RUN; not reachable in
  // normal operation, but it drops the FSM out of RUN instead of spinning.
  assign w_underflow = w_borrow[DIGITS];

  for (genvar gd = 0; gd < DIGITS; gd++) begin : g_digit
    bcd_digit_down u_digit (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .load       (w_dig_load),
      .load_digit (w_dig_value[gd*BCD_W +: BCD_W]),
      .dec        (w_borrow[gd]),
      .digit      (count[gd*BCD_W +: BCD_W]),
      .borrow_out (w_borrow[gd+1])
    );
  end

  // Reload register tracks the most recent clamped preset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_reload <= '0;
    end else if (load) begin
      r_reload <= w_load_clamped;
    end
  end

  // Next-state and done decode; priority load > pause > start > tick_en.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    if (load) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (!pause && start && !zero) begin
            w_state_nxt = RUN;
          end
        end
        RUN: begin
          if (pause) begin
            w_state_nxt = PAUSED;
          end else if (w_expire) begin
            w_done_nxt = 1'b1;
`ifdef BCD_DOWNCOUNT_RELOAD_EN
            w_state_nxt = RUN;
`else
            w_state_nxt = IDLE;
`endif
          end else if (w_underflow) begin
            w_state_nxt = IDLE;
          end
        end
        PAUSED: begin
          if (!pause && start && !zero) begin
            w_state_nxt = RUN;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // State, busy and done registers; busy mirrors the state being entered.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == RUN);
      r_done  <= w_done_nxt;
    end
  end

  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_bcd_downcount.sv
// Directed bench for bcd_downcount (DIGITS = 4). Inputs change 1 time unit
// after each rising edge; outputs are sampled at that same point.
module tb_bcd_downcount;

`ifdef BCD_DOWNCOUNT_RELOAD_EN
  localparam bit RELOAD = 1'b1;
`else
  localparam bit RELOAD = 1'b0;
`endif

  logic        CLK;
  logic        RST_N;
  logic        load;
  logic [15:0] load_value;
  logic        start;
  logic        pause;
  logic        tick_en;
  logic [15:0] count;
  logic        zero;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_downcount #(.DIGITS(4)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .pause      (pause),
    .tick_en    (tick_en),
    .count      (count),
    .zero       (zero),
    .busy       (busy),
    .done       (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; load = 1'b0; load_value = 16'h0; start = 1'b0; pause = 1'b0; tick_en = 1'b0;
    #12;
    n_checks++; if (count !== 16'h0000) begin n_fail++; $display("FAIL reset_init_count got=%h exp=0000", count); end
    n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL reset_init_zero got=%b exp=1", zero); end
    RST_N = 1'b1;
    step();
    load = 1'b1; load_value = 16'h0457;
    step();
    load = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    n_checks++; if (count !== 16'h0457) begin n_fail++; $display("FAIL reset_pre_count got=%h exp=0457", count); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_pre_busy got=%b exp=1", busy); end
    #3 RST_N = 1'b0;
    #1;
    n_checks++; if (count !== 16'h0000) begin n_fail++; $display("FAIL reset_async_count got=%h exp=0000", count); end
    n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL reset_async_zero got=%b exp=1", zero); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_async_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_async_done got=%b exp=0", done); end
    #2 RST_N = 1'b1;
    step();
    n_checks++; if (busy !== 1'b0 || count !== 16'h0000) begin n_fail++; $display("FAIL reset_after got busy=%b count=%h exp busy=0 count=0000", busy, count); end
  endtask

  task automatic test_basic();
    logic [15:0] exp_seq [12];
    exp_seq = '{16'h0011, 16'h0010, 16'h0009, 16'h0008, 16'h0007, 16'h0006,
                16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h0000};
    if (RELOAD) exp_seq[11] = 16'h0012;
    load = 1'b1; load_value = 16'h0012;
    step();
    load = 1'b0; start = 1'b1;
    step();
    start = 1'b0; tick_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      n_checks++; if (count !== exp_seq[i]) begin n_fail++; $display("FAIL basic_count[%0d] got=%h exp=%h", i, count, exp_seq[i]); end
      n_checks++; if (done !== (i == 11)) begin n_fail++; $display("FAIL basic_done[%0d] got=%b exp=%b", i, done, (i == 11)); end
      n_checks++; if (busy !== ((i != 11) || RELOAD)) begin n_fail++; $display("FAIL basic_busy[%0d] got=%b exp=%b", i, busy, ((i != 11) || RELOAD)); end
    end
    tick_en = 1'b0;
    step();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_after got=%b exp=0", done); end
    n_checks++; if (busy !== RELOAD) begin n_fail++; $display("FAIL basic_busy_after got=%b exp=%b", busy, RELOAD); end
    n_checks++; if (zero !== !RELOAD) begin n_fail++; $display("FAIL basic_zero_after got=%b exp=%b", zero, !RELOAD); end
  endtask

  task automatic test_borrow();
    load = 1'b1; load_value = 16'h1000;
    step();
    load = 1'b0; start = 1'b1;
    step();
    start = 1'b0; tick_en = 1'b1;
    step();
    tick_en = 1'b0;
    n_checks++; if (count !== 16'h0999) begin n_fail++; $display("FAIL borrow_count got=%h exp=0999", count); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL borrow_done got=%b exp=0", done); end
    load = 1'b1; load_value = 16'h0000;
    step();
    load = 1'b0;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || zero !== 1'b1 || count !== 16'h0000)
      begin n_fail++; $display("FAIL borrow_abort got busy=%b done=%b zero=%b count=%h exp 0 0 1 0000", busy, done, zero, count); end
    start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL borrow_start_zero[%0d] got busy=%b done=%b exp 0 0", i, busy, done); end
    end
    start = 1'b0;
  endtask

  task automatic test_pause();
    load = 1'b1; load_value = 16'h0051;
    step();
    load = 1'b0; start = 1'b1;
    step();
    start = 1'b0; tick_en = 1'b1;
    step();
    n_checks++; if (count !== 16'h0050) begin n_fail++; $display("FAIL pause_setup got=%h exp=0050", count); end
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++; if (count !== 16'h0050 || busy !== 1'b0) begin n_fail++; $display("FAIL pause_hold[%0d] got count=%h busy=%b exp 0050 0", i, count, busy); end
    end
    pause = 1'b0; tick_en = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    n_checks++; if (busy !== 1'b1 || count !== 16'h0050) begin n_fail++; $display("FAIL pause_resume got busy=%b count=%h exp 1 0050", busy, count); end
    tick_en = 1'b1;
    step();
    tick_en = 1'b0;
    n_checks++; if (count !== 16'h0049) begin n_fail++; $display("FAIL pause_tick got=%h exp=0049", count); end
    load = 1'b1; load_value = 16'h0123; start = 1'b1;
    step();
    load = 1'b0; start = 1'b0;
    n_checks++; if (busy !== 1'b0 || count !== 16'h0123 || done !== 1'b0) begin n_fail++; $display("FAIL pause_load_start got busy=%b count=%h done=%b exp 0 0123 0", busy, count, done); end
    tick_en = 1'b1;
    step();
    tick_en = 1'b0;
    n_checks++; if (busy !== 1'b0 || count !== 16'h0123) begin n_fail++; $display("FAIL pause_idle_hold got busy=%b count=%h exp 0 0123", busy, count); end
  endtask

  task automatic test_clamp();
    load = 1'b1; load_value = 16'h00AF;
    step();
    n_checks++; if (count !== 16'h0099) begin n_fail++; $display("FAIL clamp_00AF got=%h exp=0099", count); end
    load_value = 16'hFA3C;
    step();
    load = 1'b0;
    n_checks++; if (count !== 16'h9939) begin n_fail++; $display("FAIL clamp_FA3C got=%h exp=9939", count); end
  endtask

`ifdef BCD_DOWNCOUNT_RELOAD_EN
  task automatic test_reload();
    logic [15:0] exp_cnt [6];
    logic        exp_done [6];
    exp_cnt  = '{16'h0002, 16'h0001, 16'h0003, 16'h0002, 16'h0001, 16'h0003};
    exp_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    load = 1'b1; load_value = 16'h0003;
    step();
    load = 1'b0; start = 1'b1;
    step();
    start = 1'b0; tick_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++; if (count !== exp_cnt[i] || done !== exp_done[i]) begin n_fail++; $display("FAIL reload[%0d] got count=%h done=%b exp %h %b", i, count, done, exp_cnt[i], exp_done[i]); end
      n_checks++; if (busy !== 1'b1 || zero !== 1'b0) begin n_fail++; $display("FAIL reload_flags[%0d] got busy=%b zero=%b exp 1 0", i, busy, zero); end
    end
    tick_en = 1'b0;
    load = 1'b1; load_value = 16'h0000;
    step();
    load = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_pause();
    test_clamp();
`ifdef BCD_DOWNCOUNT_RELOAD_EN
    test_reload();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_downcount.md
# bcd_downcount

Multi-digit BCD down-counter (countdown timer) with load, start/pause control and a terminal-count pulse. It counts in the opposite direction to the team's decade up-counter. It is loaded with a BCD preset and decrements once per `tick_en` strobe while running. It signals expiry with a one-cycle `done` pulse. It sits between a tick-generating prescaler and display/control logic in the FPGA study designs.

## Interface
- `DIGITS`, default 4: number of BCD digits; legal range 1–8.
- `CLK` in 1: single system clock, rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `load` in 1: when high at an edge, latch `load_value` into count and reload register, and force IDLE.
- `load_value` in 4*DIGITS: BCD preset; digit i is bits [4i+3:4i].
- `start` in 1: level/strobe; IDLE or PAUSED → RUN when count ≠ 0.
- `pause` in 1: RUN → PAUSED.
- `tick_en` in 1: count-enable strobe; one decrement per high cycle in RUN.
- `count` out 4*DIGITS: current BCD value, registered.
- `zero` out 1: high when `count` is all zero (combinational from the count register).
- `busy` out 1: high in RUN, registered.
- `done` out 1: one-cycle expiry pulse, registered.

## Operation
- States: IDLE, RUN, PAUSED.
- Per-edge priority: `load` > `pause` > `start` > `tick_en`.
- `load`: each digit > 9 is clamped to 9 before storage. Count and reload register take the clamped value. State becomes IDLE; `done` is 0.
- IDLE: count holds. `start` with count ≠ 0 → RUN. `start` with count = 0 is ignored, with no `done`.
- RUN:
  - `tick_en` decrements count by 1 in BCD.
  - Each digit 0 → 9 with borrow to the next digit; otherwise digit − 1.
  - Borrow ripples LSD → MSD within one cycle.
  - `pause` → PAUSED; the tick in that same cycle is dropped.
- Expiry in RUN (tick at count = 1): count → 0, `done` = 1 for exactly one cycle, state → IDLE, `busy` → 0 at the same edge.
- PAUSED: count holds and `tick_en` is ignored. `start` → RUN. `pause` and `start` together → stay PAUSED.
- `start` while already in RUN has no effect.
- `load` in RUN or PAUSED: aborts the run with no `done`. The new value is used; state → IDLE.
- Reset (asynchronous, any time): count = 0, reload register = 0, state IDLE, `busy` = 0, `done` = 0, `zero` = 1.

## Timing
- All outputs change only on the `CLK` rising edge, except the asynchronous reset assertion.
- `load`, `start` and `pause` take effect at the sampling edge. The new `count`/`busy` values are visible in the following cycle.
- Decrement latency is one cycle from a `tick_en` high edge to the updated `count`.
- `done` coincides with the first cycle in which `count` shows 0, or shows the reload value when reload is enabled.
- Back-to-back `tick_en` on every cycle is fully supported. A count of N expires after exactly N ticks in RUN.

## Configuration
- `BCD_DOWNCOUNT_RELOAD_EN` defined: auto-reload.
  - A tick at count = 1 loads the reload register instead of 0.
  - `done` still pulses and state stays RUN, so `busy` stays 1.
  - Period is N ticks; `zero` never asserts during a run.
- Not defined: the block stops at 0 and returns to IDLE as described under Operation.

## Structure
- Package `bcd_downcount_pkg` holds:
  - state enum `bcd_state_t` (IDLE, RUN, PAUSED);
  - `BCD_W = 4`;
  - `BCD_MAX = 4'd9`;
  - a clamp function for digits > 9.
- Sub-module `bcd_digit_down` implements one digit: inputs `dec` and `load`; outputs the digit and `borrow_out` (`dec` && digit == 0).
- The top level instantiates `DIGITS` of these in a generate loop, chains the borrows, and owns the FSM, reload register and `done`.

## Test plan
1. Reset: assert `RST_N` low mid-run at count 0x0457, off-edge → `count` = 0x0000, `zero` = 1, `busy` = 0, `done` = 0 immediately, without waiting for an edge.
2. Basic countdown: load 0x0012, start, `tick_en` every cycle → 0x0011, 0x0010, 0x0009, …, 0x0000 after 12 ticks. `done` is high for one cycle with that 0x0000, then `busy` = 0.
3. Borrow chain: load 0x1000, start, one tick → 0x0999. Then load 0x0000 and start → remains IDLE with no `done`.
4. Pause/priority:
   - Running at 0x0050, assert `pause` for 5 cycles with `tick_en` high → count frozen at 0x0050.
   - `start` resumes → 0x0049 on the next tick.
   - `load` and `start` in the same cycle → IDLE with the new value.
5. Clamp: load 0x00AF → `count` = 0x0099.
6. With `BCD_DOWNCOUNT_RELOAD_EN`: load 0x0003, start, tick every cycle → 3, 2, 1, then 3 with `done` high, 2, 1, 3 with `done` high. `busy` stays 1 and `zero` stays 0.
